// File: rtl/imem_instr_loader.sv
// Y86-64 instruction-memory writer: takes one decoded instruction per handshake,
// serialises it into Y86 byte order and writes it one byte per cycle.
module imem_instr_loader #(
  parameter int          ADDR_W     = 64,
  parameter int          IMEM_SIZE  = 1024,
  parameter logic [63:0] START_ADDR = 64'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       val_C,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [63:0]       next_pc,
  output logic              done,
  output logic              err_invalid,
  output logic              err_overflow
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [63:0]       next_pc_q, next_pc_d;
  logic              done_q, done_d;
  logic              err_invalid_q, err_invalid_d;
  logic              err_overflow_q, err_overflow_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        rem_q, rem_d;
  logic [71:0]       shreg_q, shreg_d;

  logic [3:0]        ilen;
  logic [79:0]       enc;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd0;
    endcase
  endfunction

  // Bytes past the instruction length are never emitted, so val_C placement
  // only has to be right for the lengths that actually carry it.
  function automatic logic [79:0] encode(input logic [3:0] ic, input logic [3:0] fn,
                                         input logic [3:0] ra, input logic [3:0] rb,
                                         input logic [63:0] vc);
    logic [79:0] e;
    e      = '0;
    e[7:0] = {ic, fn};
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
      e[15:8]  = {ra, rb};
      e[79:16] = vc;
    end else begin
      e[71:8] = vc;
    end
    return e;
  endfunction

  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    next_pc_d      = next_pc_q;
    done_d         = done_q;
    err_invalid_d  = err_invalid_q;
    err_overflow_d = err_overflow_q;
    len_d          = len_q;
    rem_d          = rem_q;
    shreg_d        = shreg_q;
    ilen           = instr_len(icode);
    enc            = encode(icode, ifun, rA, rB, val_C);

    if (clr) begin
      state_d        = IDLE;
      in_ready_d     = 1'b1;
      mem_we_d       = 1'b0;
      done_d         = 1'b0;
      next_pc_d      = START_ADDR;
      err_invalid_d  = 1'b0;
      err_overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            if (icode > 4'hB) begin
              err_invalid_d = 1'b1;
            end else if (next_pc_q + {60'd0, ilen} > 64'(IMEM_SIZE)) begin
              err_overflow_d = 1'b1;
            end else begin
              state_d     = EMIT;
              in_ready_d  = 1'b0;
              mem_we_d    = 1'b1;
              mem_addr_d  = next_pc_q[ADDR_W-1:0];
              mem_wdata_d = enc[7:0];
              shreg_d     = enc[79:8];
              len_d       = ilen;
              rem_d       = ilen - 4'd1;
              done_d      = (ilen == 4'd1);
            end
          end
        end
        EMIT: begin
          if (rem_q != 4'd0) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = mem_addr_q + ADDR_W'(1);
            mem_wdata_d = shreg_q[7:0];
            shreg_d     = shreg_q >> 8;
            rem_d       = rem_q - 4'd1;
            done_d      = (rem_q == 4'd1);
          end else begin
            mem_we_d   = 1'b0;
            done_d     = 1'b0;
            next_pc_d  = next_pc_q + {60'd0, len_q};
            state_d    = IDLE;
            in_ready_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      next_pc_q      <= START_ADDR;
      done_q         <= 1'b0;
      err_invalid_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      len_q          <= '0;
      rem_q          <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      next_pc_q      <= next_pc_d;
      done_q         <= done_d;
      err_invalid_q  <= err_invalid_d;
      err_overflow_q <= err_overflow_d;
      len_q          <= len_d;
      rem_q          <= rem_d;
    end
  end

  // Byte staging register is pure datapath and needs no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign next_pc      = next_pc_q;
  assign done         = done_q;
  assign err_invalid  = err_invalid_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_imem_instr_loader.sv
// Bench for imem_instr_loader: hand-derived vector table, corner-case sequences,
// and random instructions checked against a byte-list reference model.
module tb_imem_instr_loader;
  localparam int ADDR_W = 64;
  localparam int IMEM   = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = '0, ifun = '0, rA = '0, rB = '0;
  logic [63:0] val_C = '0;
  logic        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [63:0] next_pc;
  logic        done, err_invalid, err_overflow;

  imem_instr_loader #(.ADDR_W(ADDR_W), .IMEM_SIZE(IMEM), .START_ADDR(64'd0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .val_C(val_C),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .next_pc(next_pc),
    .done(done), .err_invalid(err_invalid), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] tb_mem [0:IMEM-1];
  int wcnt = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr[9:0]] <= mem_wdata;
      wcnt <= wcnt + 1;
    end
  end

  int n_cmp = 0, n_fail = 0;
  logic [63:0] mpc = '0;
  bit m_inv = 1'b0, m_ovf = 1'b0;

  typedef struct {
    logic [3:0]  ic, ifn, ra, rb;
    logic [63:0] vc;
    int          len;
    logic [79:0] bytes;
    logic [63:0] pc_after;
    bit          inv;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    icode = 4'($urandom); ifun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
    val_C = {$urandom, $urandom};
  endtask

  function automatic int mlen(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  function automatic logic [79:0] mbytes(input logic [3:0] ic, input logic [3:0] ifn,
                                         input logic [3:0] ra, input logic [3:0] rb,
                                         input logic [63:0] vc);
    int n;
    logic [79:0] b;
    n = mlen(ic);
    b = '0;
    b[7:0] = {ic, ifn};
    if (n == 2 || n == 10) b[15:8] = {ra, rb};
    if (n == 9)  b[71:8]  = vc;
    if (n == 10) b[79:16] = vc;
    return b;
  endfunction

  // Y86 fetch-side decode of the captured memory image
  task automatic fetch(input int pc, output logic [3:0] ic, output logic [3:0] ifn,
                       output logic [3:0] ra, output logic [3:0] rb,
                       output logic [63:0] vc, output int valp);
    int p;
    ic = tb_mem[pc][7:4]; ifn = tb_mem[pc][3:0];
    ra = 4'hF; rb = 4'hF; vc = '0; p = pc + 1;
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
      {ra, rb} = tb_mem[p]; p++;
    end
    if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) begin
      for (int i = 0; i < 8; i++) vc[8*i +: 8] = tb_mem[p + i];
      p += 8;
    end
    valp = p;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, input int elen,
                       input logic [79:0] eb, input string tag);
    int w0;
    w0 = wcnt;
    icode = ic; ifun = ifn; rA = ra; rB = rb; val_C = vc; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    scramble();
    if (elen == 0) begin
      chk({tag, "_rej_we"}, 64'(mem_we), 64'd0);
      chk({tag, "_rej_rdy"}, 64'(in_ready), 64'd1);
      chk({tag, "_rej_done"}, 64'(done), 64'd0);
      chk({tag, "_rej_pc"}, next_pc, mpc);
      chk({tag, "_rej_inv"}, 64'(err_invalid), 64'(m_inv));
      chk({tag, "_rej_ovf"}, 64'(err_overflow), 64'(m_ovf));
      cyc();
      chk({tag, "_rej_wcnt"}, 64'(wcnt), 64'(w0));
    end else begin
      for (int k = 0; k < elen; k++) begin
        if (k > 0) begin
          in_valid = 1'($urandom);
          scramble();
          cyc();
        end
        chk($sformatf("%s_we%0d", tag, k), 64'(mem_we), 64'd1);
        chk($sformatf("%s_addr%0d", tag, k), 64'(mem_addr), mpc + 64'(k));
        chk($sformatf("%s_data%0d", tag, k), 64'(mem_wdata), 64'(eb[8*k +: 8]));
        chk($sformatf("%s_done%0d", tag, k), 64'(done), 64'(k == elen - 1));
        chk($sformatf("%s_rdy%0d", tag, k), 64'(in_ready), 64'd0);
      end
      in_valid = 1'($urandom);
      cyc();
      in_valid = 1'b0;
      chk({tag, "_end_we"}, 64'(mem_we), 64'd0);
      chk({tag, "_end_done"}, 64'(done), 64'd0);
      chk({tag, "_end_rdy"}, 64'(in_ready), 64'd1);
      chk({tag, "_end_pc"}, next_pc, mpc + 64'(elen));
      chk({tag, "_end_inv"}, 64'(err_invalid), 64'(m_inv));
      chk({tag, "_end_ovf"}, 64'(err_overflow), 64'(m_ovf));
      chk({tag, "_end_wcnt"}, 64'(wcnt), 64'(w0 + elen));
      mpc += 64'(elen);
    end
  endtask

  task automatic model_instr(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [63:0] vc, input string tag);
    int n;
    n = mlen(ic);
    if (ic > 4'hB) begin
      m_inv = 1'b1; n = 0;
    end else if (mpc + 64'(n) > 64'(IMEM)) begin
      m_ovf = 1'b1; n = 0;
    end
    drive(ic, ifn, ra, rb, vc, n, mbytes(ic, ifn, ra, rb, vc), tag);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    mpc = '0; m_inv = 1'b0; m_ovf = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] dic, difn, dra, drb, ric;
    logic [63:0] dvc;
    int dvalp, start, w0, r;

    tbl[0]  = '{4'h1, 4'h0, 4'h5, 4'h6, 64'h0, 1, 80'h10, 64'd1, 1'b0};
    tbl[1]  = '{4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 10, 80'h0123456789ABCDEF_F330, 64'd11, 1'b0};
    tbl[2]  = '{4'h7, 4'h0, 4'h2, 4'h9, 64'h20, 9, 80'h2070, 64'd20, 1'b0};
    tbl[3]  = '{4'h0, 4'h0, 4'h1, 4'h1, 64'hFFFF, 1, 80'h00, 64'd21, 1'b0};
    tbl[4]  = '{4'h2, 4'h1, 4'h1, 4'h2, 64'hDEAD, 2, 80'h1221, 64'd23, 1'b0};
    tbl[5]  = '{4'h6, 4'h3, 4'h3, 4'h4, 64'h0, 2, 80'h3463, 64'd25, 1'b0};
    tbl[6]  = '{4'h4, 4'h0, 4'h5, 4'h6, 64'h10, 10, 80'h0000000000000010_5640, 64'd35, 1'b0};
    tbl[7]  = '{4'h5, 4'h0, 4'h7, 4'h8, 64'hFFFFFFFFFFFFFFF8, 10, 80'hFFFFFFFFFFFFFFF8_7850, 64'd45, 1'b0};
    tbl[8]  = '{4'h8, 4'h0, 4'hA, 4'hB, 64'h100, 9, 80'h0000000000000100_80, 64'd54, 1'b0};
    tbl[9]  = '{4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 1, 80'h90, 64'd55, 1'b0};
    tbl[10] = '{4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 2, 80'h3FA0, 64'd57, 1'b0};
    tbl[11] = '{4'hB, 4'h0, 4'h4, 4'hF, 64'h0, 2, 80'h4FB0, 64'd59, 1'b0};
    tbl[12] = '{4'hC, 4'h0, 4'h1, 4'h2, 64'h55, 0, 80'h0, 64'd59, 1'b1};

    // reset values
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_pc", next_pc, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_inv", 64'(err_invalid), 64'd0);
    chk("rst_ovf", 64'(err_overflow), 64'd0);

    // vector table
    for (int i = 0; i < 13; i++) begin
      m_inv = m_inv | tbl[i].inv;
      drive(tbl[i].ic, tbl[i].ifn, tbl[i].ra, tbl[i].rb, tbl[i].vc, tbl[i].len, tbl[i].bytes,
            $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_pc", i), next_pc, tbl[i].pc_after);
      chk($sformatf("tbl%0d_inv", i), 64'(err_invalid), 64'(tbl[i].inv));
    end

    // fetch-side decode of the table image
    for (int i = 0; i < 12; i++) begin
      start = (i == 0) ? 0 : int'(tbl[i-1].pc_after);
      fetch(start, dic, difn, dra, drb, dvc, dvalp);
      chk($sformatf("dec%0d_icode", i), 64'(dic), 64'(tbl[i].ic));
      chk($sformatf("dec%0d_ifun", i), 64'(difn), 64'(tbl[i].ifn));
      chk($sformatf("dec%0d_valp", i), 64'(dvalp), tbl[i].pc_after);
      if (tbl[i].len == 2 || tbl[i].len == 10) begin
        chk($sformatf("dec%0d_ra", i), 64'(dra), 64'(tbl[i].ra));
        chk($sformatf("dec%0d_rb", i), 64'(drb), 64'(tbl[i].rb));
      end
      if (tbl[i].len >= 9) chk($sformatf("dec%0d_valc", i), dvc, tbl[i].vc);
    end

    // clr clears sticky invalid flag and pointer
    do_clr();
    chk("clr_inv", 64'(err_invalid), 64'd0);
    chk("clr_pc", next_pc, 64'd0);
    chk("clr_rdy", 64'(in_ready), 64'd1);

    // async reset during 4th byte of mrmovq
    icode = 4'h5; ifun = 4'h0; rA = 4'h1; rB = 4'h2; val_C = 64'h1122334455667788;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("arst_b3_we", 64'(mem_we), 64'd1);
    chk("arst_b3_addr", 64'(mem_addr), 64'd3);
    w0 = wcnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we_now", 64'(mem_we), 64'd0);
    chk("arst_rdy_now", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    chk("arst_wcnt", 64'(wcnt), 64'(w0));
    chk("arst_rdy", 64'(in_ready), 64'd1);
    chk("arst_pc", next_pc, 64'd0);
    chk("arst_we", 64'(mem_we), 64'd0);
    mpc = '0; m_inv = 1'b0; m_ovf = 1'b0;

    // clr mid-EMIT
    model_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, "pre_nop");
    icode = 4'h4; ifun = 4'h0; rA = 4'h3; rB = 4'h4; val_C = 64'hCAFE;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_emit_we", 64'(mem_we), 64'd0);
    chk("clr_emit_done", 64'(done), 64'd0);
    chk("clr_emit_pc", next_pc, 64'd0);
    chk("clr_emit_rdy", 64'(in_ready), 64'd1);
    w0 = wcnt;
    repeat (2) cyc();
    chk("clr_emit_wcnt", 64'(wcnt), 64'(w0));
    mpc = '0;

    // clr together with in_valid: clr wins
    model_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, "pre_nop2");
    icode = 4'h1; ifun = 4'h0; clr = 1'b1; in_valid = 1'b1;
    cyc();
    clr = 1'b0; in_valid = 1'b0;
    chk("clrv_we", 64'(mem_we), 64'd0);
    chk("clrv_rdy", 64'(in_ready), 64'd1);
    chk("clrv_pc", next_pc, 64'd0);
    cyc();
    chk("clrv_we2", 64'(mem_we), 64'd0);
    mpc = '0;

    // fill to the end of memory and probe the overflow boundary
    for (int i = 0; i < 101; i++)
      model_instr(4'h3, 4'h0, 4'hF, 4'($urandom_range(0, 14)), {$urandom, $urandom}, "fill");
    model_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, "fill_nop");
    model_instr(4'hA, 4'h0, 4'h1, 4'hF, 64'h0, "fill_push1");
    model_instr(4'hA, 4'h0, 4'h2, 4'hF, 64'h0, "fill_push2");
    chk("fill_pc1015", next_pc, 64'd1015);
    model_instr(4'h4, 4'h0, 4'h1, 4'h2, 64'h8, "ovf_rmmov");
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    chk("ovf_pc", next_pc, 64'd1015);
    model_instr(4'h7, 4'h0, 4'h0, 4'h0, 64'hAB00_0000_0000_0000, "exact_jmp");
    chk("exact_pc", next_pc, 64'd1024);
    chk("exact_last", 64'(tb_mem[1023]), 64'hAB);
    model_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, "ovf_nop");
    chk("ovf_nop_pc", next_pc, 64'd1024);
    do_clr();
    chk("ovf_clr", 64'(err_overflow), 64'd0);

    // randomized instructions against the model
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (r < 1 || (m_ovf && r < 20)) begin
        do_clr();
        chk("rnd_clr_pc", next_pc, 64'd0);
        chk("rnd_clr_ovf", 64'(err_overflow), 64'd0);
        chk("rnd_clr_inv", 64'(err_invalid), 64'd0);
      end else begin
        if (r < 25) begin
          scramble();
          in_valid = 1'b0;
          cyc();
          chk("rnd_idle_we", 64'(mem_we), 64'd0);
        end
        ric = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
        model_instr(ric, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom},
                    $sformatf("rnd%0d", it));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
